// File: rtl/imem_dmem_arbiter_if.sv
// Request/response bundle between the IF/MEM stages, the arbiter and the unified RAM.
// master: pipeline stages plus RAM; slave: the arbiter.
interface imem_dmem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              stall_if;
   logic              stall_mem;

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      input  if_rdata, if_ack, mem_rdata, mem_ack, ram_en, ram_we, ram_addr,
             ram_wdata, stall_if, stall_mem
   );

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      output if_rdata, if_ack, mem_rdata, mem_ack, ram_en, ram_we, ram_addr,
             ram_wdata, stall_if, stall_mem
   );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Single-port RAM arbiter for the IF (fetch) and MEM (load/store) stages, one access in flight.
// ARB_PERF_CNT_EN adds saturating conflict and IF-stall counters.
module imem_dmem_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int RAM_LAT     = 1,
   parameter int MAX_IF_WAIT = 3
) (
   input logic clk,
   input logic rst,
   imem_dmem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [15:0] perf_conflicts,
   output logic [15:0] perf_if_stall
`endif
);
   localparam int LW = $clog2(RAM_LAT + 1);
   localparam int WW = $clog2(MAX_IF_WAIT + 1);
   localparam logic [LW-1:0] LAT_INIT = LW'(RAM_LAT);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_IF_WAIT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state;
   logic              grant_if;
   logic              cmd_we;
   logic [LW-1:0]     lat_cnt;
   logic [WW-1:0]     wait_cnt;
   logic              if_ack, mem_ack, ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, if_rdata, mem_rdata;
   logic              mem_wins, stall_if;

   // MEM is the older instruction, but IF is forced through once it has lost enough times.
   assign mem_wins = bus.mem_req & ~(bus.if_req & (wait_cnt == WAIT_MAX));
   assign stall_if = bus.if_req & ~if_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grant_if  <= 1'b0;
         cmd_we    <= 1'b0;
         lat_cnt   <= '0;
         wait_cnt  <= '0;
         if_ack    <= 1'b0;
         mem_ack   <= 1'b0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
      end else begin
         if_ack  <= 1'b0;
         mem_ack <= 1'b0;
         ram_en  <= 1'b0;
         ram_we  <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_wins) begin
                  grant_if  <= 1'b0;
                  cmd_we    <= bus.mem_we;
                  ram_addr  <= bus.mem_addr;
                  ram_wdata <= bus.mem_wdata;
                  ram_en    <= 1'b1;
                  ram_we    <= bus.mem_we;
                  state     <= ISSUE;
                  if (bus.if_req && wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
               end else if (bus.if_req) begin
                  grant_if <= 1'b1;
                  cmd_we   <= 1'b0;
                  ram_addr <= bus.if_addr;
                  ram_en   <= 1'b1;
                  wait_cnt <= '0;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (cmd_we) begin
                  mem_ack <= 1'b1;
                  state   <= DONE;
               end else begin
                  lat_cnt <= LAT_INIT;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (lat_cnt == LW'(1)) begin
                  if (grant_if) begin
                     if_rdata <= bus.ram_rdata;
                     if_ack   <= 1'b1;
                  end else begin
                     mem_rdata <= bus.ram_rdata;
                     mem_ack   <= 1'b1;
                  end
                  state <= DONE;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            // No arbitration here so a requester dropping req after ack is never re-granted.
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
         if (!bus.if_req) wait_cnt <= '0;
      end
   end

   assign bus.if_rdata  = if_rdata;
   assign bus.if_ack    = if_ack;
   assign bus.mem_rdata = mem_rdata;
   assign bus.mem_ack   = mem_ack;
   assign bus.ram_en    = ram_en;
   assign bus.ram_we    = ram_we;
   assign bus.ram_addr  = ram_addr;
   assign bus.ram_wdata = ram_wdata;
   assign bus.stall_if  = stall_if;
   assign bus.stall_mem = bus.mem_req & ~mem_ack;

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_conflicts <= '0;
         perf_if_stall  <= '0;
      end else begin
         if (state == IDLE && bus.if_req && bus.mem_req && perf_conflicts != 16'hFFFF)
            perf_conflicts <= perf_conflicts + 16'd1;
         if (stall_if && perf_if_stall != 16'hFFFF)
            perf_if_stall <= perf_if_stall + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: per-cycle vector table plus starvation and reset sequences.
module tb_imem_dmem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   imem_dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

`ifdef ARB_PERF_CNT_EN
   logic [15:0] perf_conflicts, perf_if_stall;
`endif

   imem_dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .RAM_LAT(1), .MAX_IF_WAIT(3)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_conflicts(perf_conflicts),
      .perf_if_stall(perf_if_stall)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous RAM, one cycle read latency.
   logic [15:0] mem [0:255];
   logic [15:0] rd_q;
   always @(posedge clk) begin
      if (rst) begin
         mem[8'h10] <= 16'hA5C3;
         mem[8'h20] <= 16'hBEEF;
         mem[8'h30] <= 16'h0F0F;
      end else if (bus.ram_en) begin
         if (bus.ram_we) mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
         else            rd_q <= mem[bus.ram_addr[7:0]];
      end
   end
   assign bus.ram_rdata = rd_q;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ctl = {if_req, mem_req, mem_we}; ex = {if_ack, mem_ack, ram_en, ram_we, stall_if, stall_mem}
   typedef struct {
      logic [2:0]  ctl;
      logic [15:0] ia, ma, md;
      logic [5:0]  ex;
      logic [15:0] e_addr, e_rd;
   } vec_t;

   vec_t tv [23];

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int grants, lat;
      logic got;
      logic [15:0] saddr;

      // IF-only load of 0x0010
      tv[0]  = '{3'b100, 16'h0010, 16'h0000, 16'h0000, 6'b000010, 16'h0000, 16'h0000};
      tv[1]  = '{3'b100, 16'h0010, 16'h0000, 16'h0000, 6'b001010, 16'h0010, 16'h0000};
      tv[2]  = '{3'b100, 16'h0010, 16'h0000, 16'h0000, 6'b000010, 16'h0000, 16'h0000};
      tv[3]  = '{3'b100, 16'h0010, 16'h0000, 16'h0000, 6'b100000, 16'h0000, 16'hA5C3};
      tv[4]  = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000};
      // MEM store 0x1234 -> 0x0040
      tv[5]  = '{3'b011, 16'h0000, 16'h0040, 16'h1234, 6'b000001, 16'h0000, 16'h0000};
      tv[6]  = '{3'b011, 16'h0000, 16'h0040, 16'h1234, 6'b001101, 16'h0040, 16'h0000};
      tv[7]  = '{3'b011, 16'h0000, 16'h0040, 16'h1234, 6'b010000, 16'h0000, 16'h0000};
      tv[8]  = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000};
      // MEM load 0x0040
      tv[9]  = '{3'b010, 16'h0000, 16'h0040, 16'h0000, 6'b000001, 16'h0000, 16'h0000};
      tv[10] = '{3'b010, 16'h0000, 16'h0040, 16'h0000, 6'b001001, 16'h0040, 16'h0000};
      tv[11] = '{3'b010, 16'h0000, 16'h0040, 16'h0000, 6'b000001, 16'h0000, 16'h0000};
      tv[12] = '{3'b010, 16'h0000, 16'h0040, 16'h0000, 6'b010000, 16'h0000, 16'h1234};
      tv[13] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000};
      // Simultaneous: MEM load 0x0010 first, then IF load 0x0020
      tv[14] = '{3'b110, 16'h0020, 16'h0010, 16'h0000, 6'b000011, 16'h0000, 16'h0000};
      tv[15] = '{3'b110, 16'h0020, 16'h0010, 16'h0000, 6'b001011, 16'h0010, 16'h0000};
      tv[16] = '{3'b110, 16'h0020, 16'h0010, 16'h0000, 6'b000011, 16'h0000, 16'h0000};
      tv[17] = '{3'b110, 16'h0020, 16'h0010, 16'h0000, 6'b010010, 16'h0000, 16'hA5C3};
      tv[18] = '{3'b100, 16'h0020, 16'h0000, 16'h0000, 6'b000010, 16'h0000, 16'h0000};
      tv[19] = '{3'b100, 16'h0020, 16'h0000, 16'h0000, 6'b001010, 16'h0020, 16'h0000};
      tv[20] = '{3'b100, 16'h0020, 16'h0000, 16'h0000, 6'b000010, 16'h0000, 16'h0000};
      tv[21] = '{3'b100, 16'h0020, 16'h0000, 16'h0000, 6'b100000, 16'h0000, 16'hBEEF};
      tv[22] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000};

      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;

      @(negedge clk); #1;
      chk("rst_if_ack",   32'(bus.if_ack), 0);
      chk("rst_mem_ack",  32'(bus.mem_ack), 0);
      chk("rst_ram_en",   32'(bus.ram_en), 0);
      chk("rst_ram_we",   32'(bus.ram_we), 0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 0);
      chk("rst_ram_wdata",32'(bus.ram_wdata), 0);
      chk("rst_if_rdata", 32'(bus.if_rdata), 0);
      chk("rst_mem_rdata",32'(bus.mem_rdata), 0);
`ifdef ARB_PERF_CNT_EN
      chk("rst_perf", 32'({perf_conflicts, perf_if_stall}), 0);
`endif
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         {bus.if_req, bus.mem_req, bus.mem_we} = tv[i].ctl;
         bus.if_addr = tv[i].ia; bus.mem_addr = tv[i].ma; bus.mem_wdata = tv[i].md;
         #1;
         chk($sformatf("vec%0d_flags", i),
             32'({bus.if_ack, bus.mem_ack, bus.ram_en, bus.ram_we, bus.stall_if, bus.stall_mem}),
             32'(tv[i].ex));
         if (tv[i].ex[3]) chk($sformatf("vec%0d_addr", i), 32'(bus.ram_addr), 32'(tv[i].e_addr));
         if (tv[i].ex[5]) chk($sformatf("vec%0d_if_rdata", i), 32'(bus.if_rdata), 32'(tv[i].e_rd));
         if (tv[i].ex[4]) chk($sformatf("vec%0d_mem_rdata", i), 32'(bus.mem_rdata), 32'(tv[i].e_rd));
      end
      chk("hold_mem_rdata", 32'(bus.mem_rdata), 32'h0000A5C3);
      chk("hold_if_rdata",  32'(bus.if_rdata),  32'h0000BEEF);
`ifdef ARB_PERF_CNT_EN
      chk("perf_conflicts", 32'(perf_conflicts), 1);
      chk("perf_if_stall",  32'(perf_if_stall), 10);
`endif

      // Starvation: back-to-back stores against a held IF fetch, two rounds.
      saddr = 16'h0080;
      for (int rnd = 0; rnd < 2; rnd++) begin
         grants = 0; got = 1'b0;
         for (int cyc = 0; cyc < 60 && !got; cyc++) begin
            @(negedge clk);
            bus.if_req = 1'b1; bus.if_addr = 16'h0010;
            bus.mem_req = 1'b1; bus.mem_we = 1'b1;
            bus.mem_addr = saddr; bus.mem_wdata = saddr ^ 16'h5555;
            #1;
            if (bus.ram_en && bus.ram_we) grants++;
            if (bus.mem_ack) saddr = saddr + 16'd1;
            if (bus.if_ack) got = 1'b1;
         end
         chk($sformatf("starve%0d_if_served", rnd), 32'(got), 1);
         chk($sformatf("starve%0d_mem_grants", rnd), 32'(grants), 3);
         chk($sformatf("starve%0d_if_rdata", rnd), 32'(bus.if_rdata), 32'h0000A5C3);
      end
      @(negedge clk);
      bus.if_req = 1'b0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
      repeat (3) @(negedge clk);

      // Reset in WAIT, then the held fetch completes.
      bus.if_req = 1'b1; bus.if_addr = 16'h0030;
      @(negedge clk); #1;
      chk("rw_issue_en", 32'(bus.ram_en), 1);
      @(negedge clk);
      rst = 1'b1; #1;
      chk("rw_rst_flags", 32'({bus.if_ack, bus.mem_ack, bus.ram_en, bus.ram_we}), 0);
      chk("rw_rst_addr",  32'(bus.ram_addr), 0);
      chk("rw_rst_stall", 32'(bus.stall_if), 1);
      @(negedge clk); #1;
      chk("rw_rst_noack", 32'(bus.if_ack), 0);
      @(negedge clk); rst = 1'b0;
      lat = 0; got = 1'b0;
      for (int cyc = 0; cyc < 10 && !got; cyc++) begin
         @(negedge clk); #1;
         lat++;
         if (bus.if_ack) got = 1'b1;
      end
      chk("rw_ack_seen",  32'(got), 1);
      chk("rw_latency",   32'(lat), 3);
      chk("rw_if_rdata",  32'(bus.if_rdata), 32'h00000F0F);
      @(negedge clk); bus.if_req = 1'b0;
      @(negedge clk); #1;
      chk("final_idle", 32'({bus.if_ack, bus.mem_ack, bus.ram_en, bus.stall_if, bus.stall_mem}), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
